// File: rtl/pic10_exec_seq_if.sv
// Bus between the PIC10 Q-cycle sequencer and the rest of the core.
// master = sequencer side, slave = core/register-file side.
interface pic10_exec_seq_if #(parameter int ADDR_W = 5);
  logic [11:0]       instr_bus;
  logic [7:0]        w_reg_bus;
  logic [7:0]        file_data_bus;
  logic [ADDR_W-1:0] file_addr;
  logic [7:0]        alu_bus;
  logic              load_w_reg;
  logic              load_file_reg;
  logic              instr_fetch;
  logic [1:0]        q_phase;
  logic              status_z;
  logic              status_dc;
  logic              status_c;

  modport master (
    input  instr_bus, w_reg_bus, file_data_bus,
    output file_addr, alu_bus, load_w_reg, load_file_reg, instr_fetch,
           q_phase, status_z, status_dc, status_c
  );

  modport slave (
    output instr_bus, w_reg_bus, file_data_bus,
    input  file_addr, alu_bus, load_w_reg, load_file_reg, instr_fetch,
           q_phase, status_z, status_dc, status_c
  );
endinterface

// File: rtl/pic10_exec_seq.sv
// PIC10 Q1..Q4 execution sequencer: latches the instruction, fetches the file
// operand, computes the ALU result and STATUS Z/DC/C, and strobes the W/file load.
module pic10_exec_seq #(
  parameter int         ADDR_W     = 5,
  parameter logic [2:0] STATUS_RST = 3'b000
) (
  input  logic              clk,
  input  logic              reset,
  pic10_exec_seq_if.master  bus
);

  typedef enum logic [1:0] {Q1 = 2'd0, Q2 = 2'd1, Q3 = 2'd2, Q4 = 2'd3} phase_t;

  typedef struct packed {
    logic       valid;
    logic       dest_f;
    logic       upd_z;
    logic       upd_c;   // also covers DC: C and DC always change together
    logic [7:0] res;
  } dec_t;

  phase_t     state, nxt;
  logic [11:0] ir;
  logic [7:0]  operand;
  logic [7:0]  alu_q;
  logic [2:0]  flags;      // {z, dc, c}
  logic [2:0]  pend;
  dec_t        dec;

  logic [7:0]  add_b;
  logic        add_cin;
  logic [8:0]  sum;
  logic [4:0]  nib;
  logic [5:0]  op6;
  logic [7:0]  k;
  logic [7:0]  w;

  assign op6 = ir[11:6];
  assign k   = ir[7:0];
  assign w   = bus.w_reg_bus;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= Q1;
    else        state <= nxt;
  end

  always_comb begin
    nxt = Q1;
    case (state)
      Q1: nxt = Q2;
      Q2: nxt = Q3;
      Q3: nxt = Q4;
      Q4: nxt = Q1;
      default: nxt = Q1;
    endcase
  end

  // One shared adder serves ADDWF, SUBWF (f + ~W + 1), DECF (f + FF) and INCF (f + 0 + 1).
  always_comb begin
    add_b   = 8'h00;
    add_cin = 1'b0;
    case (op6)
      6'b000111: add_b = w;
      6'b000010: begin add_b = ~w; add_cin = 1'b1; end
      6'b000011: add_b = 8'hFF;
      6'b001010: add_cin = 1'b1;
      default: ;
    endcase
  end

  assign sum = {1'b0, operand} + {1'b0, add_b} + {8'b0, add_cin};
  assign nib = {1'b0, operand[3:0]} + {1'b0, add_b[3:0]} + {4'b0, add_cin};

  always_comb begin
    dec = '0;
    casez (ir)
      12'b1100_????_????: begin dec.valid = 1'b1; dec.res = k; end
      12'b1101_????_????: begin dec.valid = 1'b1; dec.upd_z = 1'b1; dec.res = w | k; end
      12'b1110_????_????: begin dec.valid = 1'b1; dec.upd_z = 1'b1; dec.res = w & k; end
      12'b1111_????_????: begin dec.valid = 1'b1; dec.upd_z = 1'b1; dec.res = w ^ k; end
      12'b0000_0100_0000: begin dec.valid = 1'b1; dec.upd_z = 1'b1; dec.res = 8'h00; end
      12'b0001_00??_????: begin dec.valid = 1'b1; dec.upd_z = 1'b1; dec.res = w | operand; end
      12'b0001_01??_????: begin dec.valid = 1'b1; dec.upd_z = 1'b1; dec.res = w & operand; end
      12'b0001_10??_????: begin dec.valid = 1'b1; dec.upd_z = 1'b1; dec.res = w ^ operand; end
      12'b0001_11??_????,
      12'b0000_10??_????: begin
        dec.valid = 1'b1; dec.upd_z = 1'b1; dec.upd_c = 1'b1; dec.res = sum[7:0];
      end
      12'b0000_11??_????,
      12'b0010_10??_????: begin dec.valid = 1'b1; dec.upd_z = 1'b1; dec.res = sum[7:0]; end
      12'b0010_00??_????: begin dec.valid = 1'b1; dec.upd_z = 1'b1; dec.res = operand; end
      12'b0010_01??_????: begin dec.valid = 1'b1; dec.upd_z = 1'b1; dec.res = ~operand; end
      default: ;
    endcase
    // Literal ops and CLRW have no d bit; only file-register ops can target the file.
    dec.dest_f = dec.valid && (ir[11:10] == 2'b00) && (ir != 12'h040) && ir[5];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir      <= 12'h000;
      operand <= 8'h00;
      alu_q   <= 8'h00;
      pend    <= STATUS_RST;
      flags   <= STATUS_RST;
    end else begin
      case (state)
        Q1: ir      <= bus.instr_bus;
        Q2: operand <= bus.file_data_bus;
        Q3: begin
          alu_q <= dec.res;
          pend  <= {dec.upd_z ? (dec.res == 8'h00) : flags[2],
                    dec.upd_c ? nib[4]             : flags[1],
                    dec.upd_c ? sum[8]             : flags[0]};
        end
        Q4: flags <= pend;
        default: ;
      endcase
    end
  end

  assign bus.q_phase       = state;
  assign bus.file_addr     = ir[ADDR_W-1:0];
  assign bus.alu_bus       = alu_q;
  assign bus.instr_fetch   = (state == Q4);
  assign bus.load_w_reg    = (state == Q4) && dec.valid && !dec.dest_f;
  assign bus.load_file_reg = (state == Q4) && dec.valid &&  dec.dest_f;
  assign bus.status_z      = flags[2];
  assign bus.status_dc     = flags[1];
  assign bus.status_c      = flags[0];

endmodule

// File: tb/tb_pic10_exec_seq.sv
// Bench for pic10_exec_seq: directed scenarios plus a random instruction stream
// checked against an instruction-level model of the PIC10 ALU ops.
module tb_pic10_exec_seq;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  logic m_z = 1'b0, m_dc = 1'b0, m_c = 1'b0;
  logic [7:0] w_mirror = 8'h00;

  pic10_exec_seq_if #(.ADDR_W(5)) bus ();

  pic10_exec_seq #(.ADDR_W(5), .STATUS_RST(3'b000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Stand-in for pic10_w_reg: captures alu_bus on the edge that ends Q4.
  always @(posedge clk) if (bus.load_w_reg) w_mirror <= bus.alu_bus;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Instruction-level model: what the op does, from the opcode table.
  task automatic model(input logic [11:0] ins, input int w, input int f,
                       output logic vld, output logic to_file, output logic [7:0] res,
                       output logic nz, output logic ndc, output logic nc);
    int r;
    bit has_z, has_c;
    r = 0; vld = 1'b1; has_z = 1'b1; has_c = 1'b0;
    to_file = 1'b0;
    nz = m_z; ndc = m_dc; nc = m_c;
    if (ins[11:10] == 2'b11) begin
      case (ins[9:8])
        2'd0: begin r = ins[7:0]; has_z = 1'b0; end
        2'd1: r = w | ins[7:0];
        2'd2: r = w & ins[7:0];
        default: r = w ^ ins[7:0];
      endcase
    end else if (ins == 12'h040) begin
      r = 0;
    end else begin
      to_file = ins[5];
      case (int'(ins[11:6]))
        4:  r = w | f;
        5:  r = w & f;
        6:  r = w ^ f;
        7:  begin r = w + f; has_c = 1'b1; nc = (r > 255); ndc = ((w % 16) + (f % 16)) > 15; end
        2:  begin r = f - w; has_c = 1'b1; nc = (f >= w);  ndc = (f % 16) >= (w % 16); end
        3:  r = f - 1;
        8:  r = f;
        9:  r = 255 - f;
        10: r = f + 1;
        default: begin vld = 1'b0; to_file = 1'b0; has_z = 1'b0; r = 0; end
      endcase
    end
    res = 8'(r & 255);
    if (has_z) nz = (res == 8'h00);
    if (!has_c) begin ndc = m_dc; nc = m_c; end
  endtask

  // Called at a negedge in Q1; returns at the negedge of the following Q1.
  task automatic run_instr(input logic [11:0] ins, input logic [7:0] w, input logic [7:0] f);
    logic vld, to_file, nz, ndc, nc;
    logic [7:0] res;
    chk("phase_q1", bus.q_phase, 2'd0);
    bus.instr_bus     = ins;
    bus.w_reg_bus     = 8'($urandom);
    bus.file_data_bus = 8'($urandom);
    @(negedge clk);
    bus.instr_bus     = 12'($urandom);
    bus.file_data_bus = f;
    bus.w_reg_bus     = 8'($urandom);
    chk("file_addr", bus.file_addr, {27'd0, ins[4:0]});
    @(negedge clk);
    bus.file_data_bus = 8'($urandom);
    bus.w_reg_bus     = w;
    @(negedge clk);
    bus.w_reg_bus     = 8'($urandom);
    model(ins, int'(w), int'(f), vld, to_file, res, nz, ndc, nc);
    chk("q4_phase", bus.q_phase, 2'd3);
    chk("q4_fetch", bus.instr_fetch, 1'b1);
    chk("q4_alu", bus.alu_bus, res);
    chk("q4_load_w", bus.load_w_reg, vld && !to_file);
    chk("q4_load_f", bus.load_file_reg, vld && to_file);
    chk("q4_flags_held", {bus.status_z, bus.status_dc, bus.status_c}, {m_z, m_dc, m_c});
    @(negedge clk);
    m_z = nz; m_dc = ndc; m_c = nc;
    chk("flags", {bus.status_z, bus.status_dc, bus.status_c}, {m_z, m_dc, m_c});
    chk("strobes_off", {bus.load_w_reg, bus.load_file_reg, bus.instr_fetch}, 3'b000);
    if (vld && !to_file) chk("w_mirror", w_mirror, res);
  endtask

  initial begin
    logic [5:0] fops [9];
    logic [11:0] ins;
    logic [7:0]  f;
    int sel;
    fops = '{6'd4, 6'd5, 6'd6, 6'd7, 6'd2, 6'd3, 6'd8, 6'd9, 6'd10};
    bus.instr_bus = 12'h000; bus.w_reg_bus = 8'h00; bus.file_data_bus = 8'h00;

    // Reset held for 5 clocks
    repeat (5) @(negedge clk);
    chk("rst_phase", bus.q_phase, 2'd0);
    chk("rst_alu", bus.alu_bus, 8'h00);
    chk("rst_strobes", {bus.load_w_reg, bus.load_file_reg, bus.instr_fetch}, 3'b000);
    chk("rst_flags", {bus.status_z, bus.status_dc, bus.status_c}, 3'b000);
    reset = 1'b1;

    run_instr(12'hC55, 8'h00, 8'h00);          // MOVLW 55h
    chk("w_after_movlw", w_mirror, 8'h55);
    run_instr(12'h1C3, 8'hAA, 8'h56);          // ADDWF -> 00, Z C DC
    chk("addwf_flags", {m_z, m_dc, m_c}, 3'b111);
    run_instr(12'h0A3, 8'h01, 8'h10);          // SUBWF d=1 -> 0F
    chk("subwf_flags", {m_z, m_dc, m_c}, 3'b001);
    run_instr(12'h040, 8'h37, 8'h00);          // CLRW
    run_instr(12'h800, 8'h12, 8'h34);          // RETLW: no effect
    chk("retlw_flags", {bus.status_z, bus.status_dc, bus.status_c}, 3'b101);

    // XORLW FFh interrupted by reset in Q3
    bus.instr_bus = 12'hFFF;
    @(negedge clk); @(negedge clk);
    chk("abort_phase_q3", bus.q_phase, 2'd2);
    reset = 1'b0;
    #1;
    chk("abort_phase", bus.q_phase, 2'd0);
    chk("abort_flags", {bus.status_z, bus.status_dc, bus.status_c}, 3'b000);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_strobe", {bus.load_w_reg, bus.load_file_reg}, 2'b00);
    end
    m_z = 1'b0; m_dc = 1'b0; m_c = 1'b0;
    reset = 1'b1;
    run_instr(12'hFFF, 8'h0F, 8'h00);          // restart at Q1

    // Random stream, W chained through the mirror most of the time
    for (int i = 0; i < 80; i++) begin
      sel = $urandom_range(0, 15);
      if (sel < 4)       ins = {2'b11, 2'(sel), 8'($urandom)};
      else if (sel < 13) ins = {fops[sel-4], 6'($urandom)};
      else if (sel == 13) ins = 12'h040;
      else               ins = 12'($urandom);
      f = ($urandom_range(0, 3) == 0) ? w_mirror : 8'($urandom);
      run_instr(ins, ($urandom_range(0, 3) == 0) ? 8'($urandom) : w_mirror, f);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
